add_result_buffer: RTL and testbench

ADD_RESULT_BUFFER -- requirements
Module: add_result_buffer

---
 rtl/add_result_buffer.sv | 160 ++++++++++++++++
 tb/tb_add_result_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_buffer.sv
// rtl/add_result_buffer.sv - FIFO buffer for registered adder sums with drop accounting
//
// Purpose:
//   Captures each registered sum S from the upstream adder (one word per
//   in_valid pulse) and presents the oldest word first-word-fall-through to a
//   consumer using a valid/ready handshake. Words that arrive while the
//   buffer is full, and nothing is popped in that cycle, are discarded and
//   counted.
//
// Optional feature (macro ADD_RESULT_BUFFER_PARITY_EN):
//   When defined, an even-parity bit is stored alongside each word. out_par
//   reports the stored parity of the head entry. par_err flags a pop whose
//   stored parity disagrees with the parity recomputed from the stored data.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   one-cycle strobe, in_data holds a new sum
//   in_data    in   [WIDTH-1:0] sum word
//   out_valid  out  head entry available (level != 0)
//   out_ready  in   consumer accepts the head entry
//   out_data   out  [WIDTH-1:0] head entry (don't-care when out_valid=0)
//   level      out  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   drop_cnt   out  [7:0] words lost while full, saturating at 255
//   ovf        out  sticky, set on the first drop
//   clr_stat   in   synchronous clear of drop_cnt and ovf
//   out_par    out  (parity build) stored even parity of the head entry
//   par_err    out  (parity build) high during a pop with a parity mismatch

module add_result_buffer #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic [7:0]       drop_cnt,
    output logic             ovf,
    input  logic             clr_stat
`ifdef ADD_RESULT_BUFFER_PARITY_EN
    ,
    output logic             out_par,
    output logic             par_err
`endif
);

`ifdef ADD_RESULT_BUFFER_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Storage is deliberately not reset; occupancy alone decides validity.
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [7:0]    drop_q;
    logic          ovf_q;

    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] head_word;

    assign full = (level_q == FULL_LEVEL);

    // The head is only ever taken from storage, so a push into an empty
    // buffer becomes visible one edge later (no bypass path).
    assign pop  = (level_q != '0) && out_ready;
    // A full buffer still accepts a word when the head leaves in the same
    // cycle, keeping level at DEPTH.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

`ifdef ADD_RESULT_BUFFER_PARITY_EN
    assign wr_word = {^in_data, in_data};
`else
    assign wr_word = in_data;
`endif

    assign head_word = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers are AW bits wide; DEPTH is a power of two, so natural
    // overflow implements the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as clr_stat wins: the counter restarts at 1
    // so the lost word is never hidden by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
            ovf_q  <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (clr_stat) begin
                drop_q <= 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end else if (clr_stat) begin
            drop_q <= 8'd0;
            ovf_q  <= 1'b0;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = head_word[WIDTH-1:0];
    assign level     = level_q;
    assign drop_cnt  = drop_q;
    assign ovf       = ovf_q;

`ifdef ADD_RESULT_BUFFER_PARITY_EN
    assign out_par = head_word[WIDTH];
    assign par_err = pop && (head_word[WIDTH] != ^head_word[WIDTH-1:0]);
`endif

endmodule

// File: tb/tb_add_result_buffer.sv
// tb/tb_add_result_buffer.sv - self-checking bench for add_result_buffer

module tb_add_result_buffer;

    localparam int WIDTH = 11;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic [7:0]       drop_cnt;
    logic             ovf;
    logic             clr_stat;
`ifdef ADD_RESULT_BUFFER_PARITY_EN
    logic             out_par;
    logic             par_err;
    logic             perr_exp;
    logic             corrupt;
`endif

    int checks;
    int failures;

    add_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf),
        .clr_stat  (clr_stat)
`ifdef ADD_RESULT_BUFFER_PARITY_EN
        ,
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of accepted words plus statistics.
    logic [WIDTH-1:0] mq[$];
    int               m_cnt;
    logic             m_ovf;
    logic [WIDTH-1:0] got[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt <= 0;
            m_ovf <= 1'b0;
        end else begin
            automatic bit do_pop  = (mq.size() != 0) && out_ready;
            automatic bit do_drop = in_valid && (mq.size() == DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (in_valid && !do_drop) mq.push_back(in_data);
            if (do_drop) begin
                m_ovf <= 1'b1;
                m_cnt <= clr_stat ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            end else if (clr_stat) begin
                m_cnt <= 0;
                m_ovf <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", int'(out_valid), int'(mq.size() != 0));
            check("level", int'(level), mq.size());
            check("drop_cnt", int'(drop_cnt), m_cnt);
            check("ovf", int'(ovf), int'(m_ovf));
            if (mq.size() != 0) begin
                check("out_data", int'(out_data), int'(mq[0]));
`ifdef ADD_RESULT_BUFFER_PARITY_EN
                if (!corrupt) check("out_par", int'(out_par), int'(^mq[0]));
`endif
            end
`ifdef ADD_RESULT_BUFFER_PARITY_EN
            check("par_err", int'(par_err), int'(perr_exp));
`endif
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (mq.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        out_ready = 1'b0;
        check("drain_timeout", int'(budget < 50), 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        clr_stat = 1'b0;
`ifdef ADD_RESULT_BUFFER_PARITY_EN
        perr_exp = 1'b0;
        corrupt  = 1'b0;
`endif
        #12;
        check("reset_valid", int'(out_valid), 0);
        check("reset_level", int'(level), 0);
        check("reset_drop", int'(drop_cnt), 0);
        check("reset_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic ordering with backpressure.
        push_word(11'h001);
        push_word(11'h7FF);
        push_word(11'h400);
        check("lit_level3", int'(level), 3);
        check("lit_head001", int'(out_data), 11'h001);
        got.delete();
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        check("lit_seq_len", got.size(), 3);
        if (got.size() == 3) begin
            check("lit_seq0", int'(got[0]), 11'h001);
            check("lit_seq1", int'(got[1]), 11'h7FF);
            check("lit_seq2", int'(got[2]), 11'h400);
        end
        check("lit_level0", int'(level), 0);

        // Overflow: fill, then three lost words.
        for (int i = 0; i < 4; i++) push_word(WIDTH'(11'h010 + i));
        for (int i = 0; i < 3; i++) push_word(WIDTH'(11'h050 + i));
        check("lit_full_level", int'(level), 4);
        check("lit_drop3", int'(drop_cnt), 3);
        check("lit_ovf", int'(ovf), 1);
        check("lit_head_keep", int'(out_data), 11'h010);

        // Full with simultaneous pop: no drop.
        out_ready = 1'b1;
        push_word(11'h123);
        out_ready = 1'b0;
        check("lit_fullpop_level", int'(level), 4);
        check("lit_fullpop_drop", int'(drop_cnt), 3);
        check("lit_fullpop_head", int'(out_data), 11'h011);
        got.delete();
        drain();
        check("lit_tail123", got.size() == 4 ? int'(got[3]) : -1, 11'h123);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("lit_clr_drop", int'(drop_cnt), 0);
        check("lit_clr_ovf", int'(ovf), 0);

        // Ten words across pointer wrap with irregular consumer.
        got.delete();
        begin
            int sent, budget;
            sent = 0;
            budget = 0;
            while ((sent < 10 || mq.size() != 0) && budget < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (sent < 10 && mq.size() < DEPTH && ($urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    in_data  = WIDTH'(sent);
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
                step();
                budget++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("wrap_timeout", int'(budget < 200), 1);
        end
        check("lit_wrap_len", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) check("lit_wrap_order", int'(got[i]), i);

        // Asynchronous reset mid-stream.
        push_word(11'h0AA);
        push_word(11'h0BB);
        check("lit_level2", int'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("lit_async_valid", int'(out_valid), 0);
        check("lit_async_level", int'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // clr_stat coinciding with a drop.
        for (int i = 0; i < 4; i++) push_word(WIDTH'(11'h200 + i));
        push_word(11'h2FF);
        check("lit_drop1", int'(drop_cnt), 1);
        clr_stat = 1'b1;
        push_word(11'h2FE);
        clr_stat = 1'b0;
        check("lit_clr_drop_prio", int'(drop_cnt), 1);
        check("lit_clr_ovf_prio", int'(ovf), 1);

        // Saturation at 255.
        in_valid = 1'b1;
        in_data  = 11'h3AB;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
        check("lit_sat", int'(drop_cnt), 255);
        drain();

`ifdef ADD_RESULT_BUFFER_PARITY_EN
        push_word(11'h007);
        check("lit_par", int'(out_par), 1);
        dut.mem[dut.rd_ptr][WIDTH] = ~dut.mem[dut.rd_ptr][WIDTH];
        corrupt   = 1'b1;
        perr_exp  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        perr_exp  = 1'b0;
        corrupt   = 1'b0;
        step();
        check("lit_perr_clear", int'(par_err), 0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
